// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of a single acked slave bus.
// One transfer in flight at a time; a transfer that is never acked is aborted with an error.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          m0_strobe,
   input  logic          m0_rw,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   output logic          m0_err,
   input  logic          m1_strobe,
   input  logic          m1_rw,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic          s_strobe,
   output logic          s_rw,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_ack,
   output logic [1:0]    grant
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       last_m1;
   logic [7:0] cnt;
   logic       pick_m1;

   // m1 wins when it is the only requester, or on a tie when m0 owned the bus last.
   assign pick_m1 = m1_strobe & (~m0_strobe | ~last_m1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         last_m1  <= 1'b1;
         cnt      <= '0;
         grant    <= 2'b00;
         s_strobe <= 1'b0;
         s_rw     <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         m0_rdata <= '0;
         m0_ack   <= 1'b0;
         m0_err   <= 1'b0;
         m1_rdata <= '0;
         m1_ack   <= 1'b0;
         m1_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_strobe || m1_strobe) begin
                  s_rw     <= pick_m1 ? m1_rw    : m0_rw;
                  s_addr   <= pick_m1 ? m1_addr  : m0_addr;
                  s_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                  s_strobe <= 1'b1;
                  grant    <= pick_m1 ? 2'b10 : 2'b01;
                  last_m1  <= pick_m1;
                  cnt      <= '0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               // An ack arriving on the expiry cycle is a normal completion.
               if (s_ack) begin
                  s_strobe <= 1'b0;
                  state    <= DONE;
                  if (grant[1]) begin
                     if (!s_rw) m1_rdata <= s_rdata;
                     m1_ack <= m1_strobe;
                  end else begin
                     if (!s_rw) m0_rdata <= s_rdata;
                     m0_ack <= m0_strobe;
                  end
               end else if (cnt == CNT_LAST) begin
                  s_strobe <= 1'b0;
                  state    <= DONE;
                  if (grant[1]) begin
                     m1_rdata <= '0;
                     m1_ack   <= m1_strobe;
                     m1_err   <= m1_strobe;
                  end else begin
                     m0_rdata <= '0;
                     m0_ack   <= m0_strobe;
                     m0_err   <= m0_strobe;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               m0_ack <= 1'b0;
               m0_err <= 1'b0;
               m1_ack <= 1'b0;
               m1_err <= 1'b0;
               grant  <= 2'b00;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, tie alternation, timeout,
// asynchronous reset mid-transfer and strobe drop during a transfer.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          m0_strobe, m0_rw, m1_strobe, m1_rw;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic          s_strobe, s_rw, s_ack;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic [1:0]    grant;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_strobe(m0_strobe), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_strobe(m1_strobe), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_strobe(s_strobe), .s_rw(s_rw), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      m0_strobe = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_strobe = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_wdata = '0;
      s_ack     = 1'b0; s_rdata = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      if ({s_strobe, grant, m0_ack, m0_err, m1_ack, m1_err} !== 7'b0) begin
         $display("FAIL reset_ctrl: got %b want 0", {s_strobe, grant, m0_ack, m0_err, m1_ack, m1_err});
         tests_failed++;
      end
      tests_run++;
      if ({m0_rdata, m1_rdata, s_addr, s_wdata, s_rw} !== '0) begin
         $display("FAIL reset_data: got %h %h %h %h want 0", m0_rdata, m1_rdata, s_addr, s_wdata);
         tests_failed++;
      end
      tests_run++;
   endtask

   task automatic test_read();
      int hi;
      do_reset();
      m0_strobe = 1'b1; m0_rw = 1'b0; m0_addr = 32'h100;
      tick();
      if (grant !== 2'b01 || s_addr !== 32'h100 || s_rw !== 1'b0) begin
         $display("FAIL read_grant: got grant=%b addr=%h rw=%b want 01 100 0", grant, s_addr, s_rw);
         tests_failed++;
      end
      tests_run++;
      hi = 0;
      for (int i = 0; i < 2; i++) begin
         if (s_strobe) hi++;
         tick();
      end
      if (s_strobe) hi++;
      s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
      tick();
      if (s_strobe) hi++;
      s_ack = 1'b0;
      if (hi !== 3) begin
         $display("FAIL read_strobe_len: got %0d want 3", hi);
         tests_failed++;
      end
      tests_run++;
      if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         $display("FAIL read_done: got ack=%b err=%b rdata=%h want 1 0 deadbeef", m0_ack, m0_err, m0_rdata);
         tests_failed++;
      end
      tests_run++;
      m0_strobe = 1'b0;
      tick();
      if (m0_ack !== 1'b0 || grant !== 2'b00) begin
         $display("FAIL read_ack_pulse: got ack=%b grant=%b want 0 00", m0_ack, grant);
         tests_failed++;
      end
      tests_run++;
      tick();
      if (s_strobe !== 1'b0 || grant !== 2'b00) begin
         $display("FAIL read_idle: got strobe=%b grant=%b want 0 00", s_strobe, grant);
         tests_failed++;
      end
      tests_run++;
   endtask

   task automatic test_tie();
      logic [1:0] exp_g [4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      m0_strobe = 1'b1; m0_rw = 1'b0; m0_addr = 32'h10;
      m1_strobe = 1'b1; m1_rw = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (grant !== exp_g[i] || s_addr !== (exp_g[i][1] ? 32'h20 : 32'h10)) begin
            $display("FAIL tie_grant[%0d]: got grant=%b addr=%h want %b", i, grant, s_addr, exp_g[i]);
            tests_failed++;
         end
         tests_run++;
         s_ack = 1'b1; s_rdata = 32'h0000_0A00 + 32'(i);
         tick();
         s_ack = 1'b0;
         if ({m1_ack, m0_ack} !== exp_g[i]) begin
            $display("FAIL tie_ack[%0d]: got %b want %b", i, {m1_ack, m0_ack}, exp_g[i]);
            tests_failed++;
         end
         tests_run++;
         tick();
         if (grant !== 2'b00) begin
            $display("FAIL tie_gap[%0d]: got %b want 00", i, grant);
            tests_failed++;
         end
         tests_run++;
      end
      if (m0_rdata !== 32'h0000_0A02 || m1_rdata !== 32'h0) begin
         $display("FAIL tie_rdata: got m0=%h m1=%h want 00000a02 0", m0_rdata, m1_rdata);
         tests_failed++;
      end
      tests_run++;
      m0_strobe = 1'b0; m1_strobe = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      // Preload m1_rdata so the timeout clearing it is observable.
      m1_strobe = 1'b1; m1_rw = 1'b0; m1_addr = 32'h40;
      tick();
      s_ack = 1'b1; s_rdata = 32'h1234_5678;
      tick();
      s_ack = 1'b0; m1_strobe = 1'b0;
      tick();
      if (m1_rdata !== 32'h1234_5678) begin
         $display("FAIL to_preload: got %h want 12345678", m1_rdata);
         tests_failed++;
      end
      tests_run++;
      m1_strobe = 1'b1; m1_rw = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h5;
      tick();
      if (grant !== 2'b10 || s_wdata !== 32'h5 || s_rw !== 1'b1) begin
         $display("FAIL to_grant: got grant=%b wdata=%h rw=%b want 10 5 1", grant, s_wdata, s_rw);
         tests_failed++;
      end
      tests_run++;
      n = 0;
      while (!m1_ack && n < 40) begin
         tick();
         n++;
      end
      if (n !== 15) begin
         $display("FAIL to_cycles: got %0d want 15", n);
         tests_failed++;
      end
      tests_run++;
      if (m1_err !== 1'b1 || m1_rdata !== 32'h0 || s_strobe !== 1'b0) begin
         $display("FAIL to_abort: got err=%b rdata=%h strobe=%b want 1 0 0", m1_err, m1_rdata, s_strobe);
         tests_failed++;
      end
      tests_run++;
      m1_strobe = 1'b0;
      tick();
      m1_strobe = 1'b1;
      tick();
      for (int i = 0; i < 14; i++) tick();
      if (m1_ack !== 1'b0) begin
         $display("FAIL to_early_ack: got %b want 0", m1_ack);
         tests_failed++;
      end
      tests_run++;
      s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
      tick();
      s_ack = 1'b0;
      if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'h0) begin
         $display("FAIL to_ack_wins: got ack=%b err=%b rdata=%h want 1 0 0", m1_ack, m1_err, m1_rdata);
         tests_failed++;
      end
      tests_run++;
      m1_strobe = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      m1_strobe = 1'b1; m1_rw = 1'b0; m1_addr = 32'h80;
      tick();
      m0_strobe = 1'b1; m0_addr = 32'h90;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      if (s_strobe !== 1'b0 || grant !== 2'b00 || {m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin
         $display("FAIL areset_clear: got strobe=%b grant=%b acks=%b want 0 00 0", s_strobe, grant,
                  {m0_ack, m1_ack, m0_err, m1_err});
         tests_failed++;
      end
      tests_run++;
      reset_n = 1'b1;
      tick();
      if (grant !== 2'b01 || s_addr !== 32'h90) begin
         $display("FAIL areset_tie: got grant=%b addr=%h want 01 90", grant, s_addr);
         tests_failed++;
      end
      tests_run++;
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0; m0_strobe = 1'b0; m1_strobe = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_drop();
      do_reset();
      m0_strobe = 1'b1; m0_rw = 1'b0; m0_addr = 32'h300;
      tick();
      m0_strobe = 1'b0;
      m1_strobe = 1'b1; m1_rw = 1'b0; m1_addr = 32'h400;
      s_ack = 1'b1; s_rdata = 32'hCAFEF00D;
      tick();
      s_ack = 1'b0;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_rdata !== 32'hCAFEF00D || m1_rdata !== 32'h0) begin
         $display("FAIL drop_suppress: got ack0=%b ack1=%b rd0=%h rd1=%h want 0 0 cafef00d 0",
                  m0_ack, m1_ack, m0_rdata, m1_rdata);
         tests_failed++;
      end
      tests_run++;
      tick();
      if (grant !== 2'b00 || s_strobe !== 1'b0) begin
         $display("FAIL drop_done: got grant=%b strobe=%b want 00 0", grant, s_strobe);
         tests_failed++;
      end
      tests_run++;
      tick();
      if (grant !== 2'b10 || s_addr !== 32'h400 || s_strobe !== 1'b1) begin
         $display("FAIL drop_next: got grant=%b addr=%h strobe=%b want 10 400 1", grant, s_addr, s_strobe);
         tests_failed++;
      end
      tests_run++;
      s_ack = 1'b1; s_rdata = 32'h0BAD_0BAD;
      tick();
      s_ack = 1'b0;
      if (m1_ack !== 1'b1 || m1_rdata !== 32'h0BAD_0BAD || m0_rdata !== 32'hCAFEF00D) begin
         $display("FAIL drop_m1_done: got ack=%b rd1=%h rd0=%h want 1 0bad0bad cafef00d", m1_ack, m1_rdata, m0_rdata);
         tests_failed++;
      end
      tests_run++;
      m1_strobe = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_read();
      test_tie();
      test_timeout();
      test_async_reset();
      test_drop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
